// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger/capture block.
// Holds the capture FSM state encoding and the buffer address-width derivation.
package scope_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_DEPTH  = 512;

   typedef enum logic [2:0] {
      IDLE,
      PRE_FILL,
      WAIT_TRIG,
      POST_FILL,
      DONE
   } state_t;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Only the read register is reset; the array itself is left for block-RAM inference.
module scope_sample_ram
   import scope_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/scope_trigger_capture.sv
// Oscilloscope capture: samples adc_data on each rising edge of sample_clk, waits for a
// level/slope trigger (or timeout), and stores a pre/post-trigger window in a ring buffer.
module scope_trigger_capture
   import scope_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int PRETRIG      = 128,
   parameter int AUTO_TIMEOUT = 65535,
   localparam int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_clk,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              arm,
   input  logic              abort,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              auto_trig
);

   localparam int          CNT_W    = ADDR_W + 1;
   localparam int          POST_LEN = DEPTH - PRETRIG;
   localparam logic [15:0] TO_LAST  = 16'(AUTO_TIMEOUT - 1);

   state_t              state, state_nx;
   logic                sample_d;
   logic                strobe;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   trig_ptr;
   logic [CNT_W-1:0]    cnt;
   logic [15:0]         to_cnt;
   logic [DATA_W-1:0]   prev_sample;
   logic                hit;
   logic                forced;
   logic                wr_en;
   logic                start_cap;
   logic                fire;
   logic [ADDR_W-1:0]   rd_phys;

   // One strobe per divided period, independent of how long sample_clk stays high.
   assign strobe = sample_clk & ~sample_d;

   assign busy = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);
   assign done = (state == DONE);

   always_comb begin
      hit    = 1'b0;
      forced = 1'b0;
      if (trig_rising) begin
         hit = (prev_sample < trig_level) && (adc_data >= trig_level);
      end else begin
         hit = (prev_sample > trig_level) && (adc_data <= trig_level);
      end
      forced = (AUTO_TIMEOUT != 0) && (to_cnt == TO_LAST);
   end

   assign wr_en = busy & strobe & ~abort;

   always_comb begin
      state_nx  = state;
      start_cap = 1'b0;
      fire      = 1'b0;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  state_nx  = PRE_FILL;
                  start_cap = 1'b1;
               end
            end
            PRE_FILL: begin
               if (strobe && cnt == CNT_W'(PRETRIG - 1)) begin
                  state_nx = WAIT_TRIG;
               end
            end
            WAIT_TRIG: begin
               if (strobe && (hit || forced)) begin
                  fire     = 1'b1;
                  state_nx = (POST_LEN == 1) ? DONE : POST_FILL;
               end
            end
            POST_FILL: begin
               if (strobe && cnt == CNT_W'(POST_LEN - 1)) begin
                  state_nx = DONE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         sample_d    <= 1'b0;
         wr_ptr      <= '0;
         trig_ptr    <= '0;
         cnt         <= '0;
         to_cnt      <= '0;
         prev_sample <= '0;
         auto_trig   <= 1'b0;
      end else begin
         state    <= state_nx;
         sample_d <= sample_clk;
         if (start_cap) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            auto_trig <= 1'b0;
         end else if (wr_en) begin
            wr_ptr      <= wr_ptr + 1'b1;
            prev_sample <= adc_data;
            case (state)
               PRE_FILL: begin
                  cnt <= (cnt == CNT_W'(PRETRIG - 1)) ? '0 : cnt + 1'b1;
               end
               WAIT_TRIG: begin
                  if (fire) begin
                     trig_ptr  <= wr_ptr;
                     auto_trig <= forced & ~hit;
                     cnt       <= CNT_W'(1);
                  end else begin
                     to_cnt <= to_cnt + 16'd1;
                  end
               end
               POST_FILL: cnt <= cnt + 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Logical index 0 is the oldest retained pre-trigger sample.
   assign rd_phys = trig_ptr - ADDR_W'(PRETRIG) + rd_addr;

   scope_sample_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (adc_data),
      .rd_addr (rd_phys),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: a sample-sequence model predicts the trigger index,
// strobe count to done, auto flag, and the trigger-aligned buffer readout.
module tb_scope_trigger_capture;

   localparam int DATA_W       = 12;
   localparam int DEPTH        = 16;
   localparam int ADDR_W       = 4;
   localparam int PRETRIG      = 4;
   localparam int AUTO_TIMEOUT = 32;
   localparam int POST_LEN     = DEPTH - PRETRIG;
   localparam int NS           = 128;

   logic              clock = 1'b0;
   logic              reset;
   logic              sample_clk;
   logic [DATA_W-1:0] adc_data;
   logic              arm;
   logic              abort;
   logic [DATA_W-1:0] trig_level;
   logic              trig_rising;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              auto_trig;

   int smp [NS];
   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] exp_q [$];

   scope_trigger_capture #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .PRETRIG      (PRETRIG),
      .AUTO_TIMEOUT (AUTO_TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sample_clk  (sample_clk),
      .adc_data    (adc_data),
      .arm         (arm),
      .abort       (abort),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .auto_trig   (auto_trig)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: first WAIT_TRIG sample is index PRETRIG; trigger at first slope crossing
   // against the previous sample, or forced on the AUTO_TIMEOUT-th WAIT_TRIG sample.
   function automatic int model_trig(input int lvl, input bit rising, output bit auto_only);
      bit h;
      bit f;
      auto_only = 1'b0;
      for (int k = PRETRIG; k < NS; k++) begin
         h = rising ? (smp[k-1] < lvl && smp[k] >= lvl) : (smp[k-1] > lvl && smp[k] <= lvl);
         f = (AUTO_TIMEOUT != 0) && (k - PRETRIG == AUTO_TIMEOUT - 1);
         if (h || f) begin
            auto_only = f && !h;
            return k;
         end
      end
      return -1;
   endfunction

   // driver tasks
   task automatic do_sample(input int v, input int hi, input int lo);
      adc_data   = DATA_W'(v);
      sample_clk = 1'b1;
      repeat (hi) @(negedge clock);
      sample_clk = 1'b0;
      repeat (lo) @(negedge clock);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clock);
      arm = 1'b0;
   endtask

   task automatic run_capture(input string name, input int lvl, input bit rising,
                              input int hi, input int lo, input bit arm_mid);
      int  t;
      int  n;
      bit  a_exp;
      t = model_trig(lvl, rising, a_exp);
      trig_level  = DATA_W'(lvl);
      trig_rising = rising;
      pulse_arm();
      check({name, " busy_after_arm"}, busy, 1);
      check({name, " done_after_arm"}, done, 0);
      n = 0;
      while (!done && n < NS - 8) begin
         do_sample(smp[n], hi, lo);
         n++;
         if (arm_mid && n == PRETRIG + 2 && !done) pulse_arm();
      end
      check({name, " strobes_to_done"}, n, t + POST_LEN);
      check({name, " done"}, done, 1);
      check({name, " busy_at_done"}, busy, 0);
      check({name, " auto_trig"}, auto_trig, a_exp);
      // strobes after completion must not disturb the buffer
      for (int i = 0; i < 3; i++) do_sample($urandom_range(0, 4095), hi, lo);
      check({name, " done_holds"}, done, 1);
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++) exp_q.push_back(DATA_W'(smp[t - PRETRIG + a]));
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = ADDR_W'(a);
         @(negedge clock);
         check($sformatf("%s rd_data[%0d]", name, a), rd_data, exp_q.pop_front());
      end
   endtask

   // Capture interrupted a few strobes into POST_FILL, by abort or by reset.
   task automatic run_interrupted(input string name, input int lvl, input bit use_reset);
      int t;
      bit a_exp;
      t = model_trig(lvl, 1'b1, a_exp);
      trig_level  = DATA_W'(lvl);
      trig_rising = 1'b1;
      pulse_arm();
      for (int i = 0; i < t + 3; i++) do_sample(smp[i], 10, 10);
      check({name, " busy_before_cut"}, busy, 1);
      if (use_reset) begin
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         check({name, " rd_data_reset"}, rd_data, 0);
         check({name, " auto_trig_reset"}, auto_trig, 0);
      end else begin
         abort = 1'b1;
         @(negedge clock);
         abort = 1'b0;
      end
      check({name, " busy_cut"}, busy, 0);
      check({name, " done_cut"}, done, 0);
      run_capture({name, "_rearm"}, lvl, 1'b1, 20 - 10, 10, 1'b0);
   endtask

   initial begin
      int hi;
      int lo;
      reset       = 1'b1;
      sample_clk  = 1'b0;
      adc_data    = '0;
      arm         = 1'b0;
      abort       = 1'b0;
      trig_level  = '0;
      trig_rising = 1'b1;
      rd_addr     = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset auto_trig", auto_trig, 0);
      check("reset rd_data", rd_data, 0);

      // rising ramp 0,100,200,...
      for (int i = 0; i < NS; i++) smp[i] = (100 * i > 4095) ? 4095 : 100 * i;
      run_capture("rise", 1000, 1'b1, 10, 10, 1'b0);

      // falling ramp: the 1400 crossing lands inside pre-fill and must be ignored
      for (int i = 0; i < NS; i++) smp[i] = (1500 - 100 * i < 0) ? 0 : 1500 - 100 * i;
      run_capture("fall", 1400, 1'b0, 10, 10, 1'b0);

      for (int i = 0; i < NS; i++) smp[i] = 500;
      run_capture("auto", 1000, 1'b1, 10, 10, 1'b1);

      for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
      run_interrupted("abort", 2048, 1'b0);
      for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
      run_interrupted("rst", 2048, 1'b1);

      // long high time, 20-sample dwell in WAIT_TRIG, ring wraps twice
      for (int i = 0; i < NS; i++) smp[i] = (i >= PRETRIG + 20) ? 3000 + i : i;
      run_capture("wrap", 2000, 1'b1, 200, 10, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
         hi = $urandom_range(1, 15);
         lo = $urandom_range(1, 15);
         run_capture($sformatf("rnd%0d", r), $urandom_range(0, 4095), 1'($urandom_range(0, 1)),
                     hi, lo, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
